// File: rtl/snn_mem_pkg.sv
// Shared constants and types for the spiking-network memory engines.
//   DATA_W  : weight / spike / current word width
//   ADDR_W  : memory address width
//   ACC_W   : signed accumulator width (DATA_W+10 covers 1023 terms)
//   SIZE_W  : width of the row/column size fields
//   state_t : sequencer states shared by the matrix engines
//   SAT_MAX / SAT_MIN : 16-bit signed current limits
package snn_mem_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 14;
    localparam int ACC_W  = 26;
    localparam int SIZE_W = 10;

    localparam int SAT_MAX = 32767;
    localparam int SAT_MIN = -32768;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ACC   = 3'd2,
        FLUSH = 3'd3,
        WRITE = 3'd4
    } state_t;

endpackage

// File: rtl/sat_narrow.sv
// Combinational signed saturation from IN_W to OUT_W bits.
//   din  : signed wide value
//   dout : din clamped to [-(2^(OUT_W-1)), 2^(OUT_W-1)-1]
module sat_narrow #(
    parameter int IN_W  = 26,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    localparam logic signed [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};

    // The value fits when every bit from the sign down to the narrow
    // result's sign bit agrees.
    logic [IN_W-OUT_W:0] top_bits;
    assign top_bits = din[IN_W-1:OUT_W-1];

    always_comb begin
        dout = din[OUT_W-1:0];
        if (!((top_bits == '0) || (top_bits == '1))) begin
            dout = din[IN_W-1] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/matrix_spike_mac.sv
// Synaptic-current stage: current[i] = sum_j W[i][j] * spike[j], saturated to
// DATA_W bits and written to the buffer the LIF layer reads.
//   clk, reset (async, active low)
//   start / done          : request pulse (IDLE only) / idle indicator
//   src1_*                : weight matrix base, N rows, K columns, read port
//   src2_*                : spike vector base, read port (bit 0 is the spike)
//   dest_*                : current buffer base and write port
// Read data returns one cycle after its address. Each row takes K+3 cycles:
// LOAD, K ACC cycles (address issue overlapped with accumulation), FLUSH
// for the last returned word, and WRITE.
module matrix_spike_mac
    import snn_mem_pkg::*;
#(
    parameter int DATA_W = snn_mem_pkg::DATA_W,
    parameter int ADDR_W = snn_mem_pkg::ADDR_W,
    parameter int ACC_W  = snn_mem_pkg::ACC_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     done,
    input  logic [ADDR_W-1:0]        src1_start_address,
    input  logic [ADDR_W-1:0]        src2_start_address,
    input  logic [SIZE_W-1:0]        src1_row_size,
    input  logic [SIZE_W-1:0]        src1_col_size,
    output logic [ADDR_W-1:0]        src1_address,
    input  logic signed [DATA_W-1:0] src1_readdata,
    output logic [ADDR_W-1:0]        src2_address,
    input  logic [DATA_W-1:0]        src2_readdata,
    input  logic [ADDR_W-1:0]        dest_start_address,
    output logic [ADDR_W-1:0]        dest_address,
    output logic signed [DATA_W-1:0] dest_writedata,
    output logic                     dest_write_en
);

    state_t state, nstate;

    logic [SIZE_W-1:0]        n_lat, k_lat;
    logic [SIZE_W-1:0]        row_i, col_j;
    logic [ADDR_W-1:0]        row_base, src2_base, dest_base;
    logic [ADDR_W-1:0]        addr1, addr2;
    logic signed [ACC_W-1:0]  acc, acc_nxt;
    logic                     rd_valid;   // address on the bus is a real request
    logic                     data_valid; // read data this cycle belongs to the row
    logic signed [DATA_W-1:0] wdata;
    logic signed [DATA_W-1:0] sat_val;
    logic                     start_ok;
    logic                     last_col, last_row;
    logic                     spike_unused;

    assign spike_unused = ^src2_readdata[DATA_W-1:1];

    assign start_ok = start && (src1_row_size != '0) && (src1_col_size != '0);
    assign last_col = (col_j == k_lat - 1'b1);
    assign last_row = (row_i == n_lat - 1'b1);

    always_comb begin
        acc_nxt = acc;
        if (data_valid && src2_readdata[0]) begin
            acc_nxt = acc + {{(ACC_W-DATA_W){src1_readdata[DATA_W-1]}}, src1_readdata};
        end
    end

    sat_narrow #(
        .IN_W  (ACC_W),
        .OUT_W (DATA_W)
    ) u_sat (
        .din  (acc_nxt),
        .dout (sat_val)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (start_ok) nstate = LOAD;
            LOAD:    nstate = ACC;
            ACC:     if (last_col) nstate = FLUSH;
            FLUSH:   nstate = WRITE;
            WRITE:   nstate = last_row ? IDLE : LOAD;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done       <= 1'b1;
            n_lat      <= '0;
            k_lat      <= '0;
            row_i      <= '0;
            col_j      <= '0;
            row_base   <= '0;
            src2_base  <= '0;
            dest_base  <= '0;
            addr1      <= '0;
            addr2      <= '0;
            acc        <= '0;
            rd_valid   <= 1'b0;
            data_valid <= 1'b0;
            wdata      <= '0;
        end else begin
            data_valid <= rd_valid;
            case (state)
                IDLE: begin
                    done <= 1'b1;
                    if (start_ok) begin
                        done      <= 1'b0;
                        n_lat     <= src1_row_size;
                        k_lat     <= src1_col_size;
                        row_i     <= '0;
                        col_j     <= '0;
                        row_base  <= src1_start_address;
                        src2_base <= src2_start_address;
                        dest_base <= dest_start_address;
                    end
                end
                LOAD: begin
                    addr1    <= row_base;
                    addr2    <= src2_base;
                    acc      <= '0;
                    rd_valid <= 1'b1;
                    col_j    <= '0;
                end
                ACC: begin
                    acc <= acc_nxt;
                    if (last_col) begin
                        rd_valid <= 1'b0;
                    end else begin
                        addr1 <= addr1 + 1'b1;
                        addr2 <= addr2 + 1'b1;
                        col_j <= col_j + 1'b1;
                    end
                end
                FLUSH: begin
                    acc   <= acc_nxt;
                    wdata <= sat_val;
                end
                WRITE: begin
                    if (!last_row) begin
                        row_i    <= row_i + 1'b1;
                        row_base <= row_base + ADDR_W'(k_lat);
                    end
                end
                default: ;
            endcase
        end
    end

    // Idle ports follow the live base inputs so they read as the base
    // addresses both out of reset and between jobs.
    assign src1_address   = (state == IDLE) ? src1_start_address : addr1;
    assign src2_address   = (state == IDLE) ? src2_start_address : addr2;
    assign dest_address   = (state == IDLE) ? dest_start_address
                                            : dest_base + ADDR_W'(row_i);
    assign dest_write_en  = (state == WRITE);
    assign dest_writedata = wdata;

endmodule

// File: tb/tb_matrix_spike_mac.sv
module tb_matrix_spike_mac;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic               done;
    logic [13:0]        s1_start = '0, s2_start = '0, d_start = '0;
    logic [9:0]         n_size = '0, k_size = '0;
    logic [13:0]        src1_address, src2_address, dest_address;
    logic signed [15:0] src1_readdata;
    logic [15:0]        src2_readdata;
    logic signed [15:0] dest_writedata;
    logic               dest_write_en;

    logic [15:0] mem1 [0:16383];
    logic [15:0] mem2 [0:16383];
    int          wr_addr [$];
    int          wr_data [$];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    matrix_spike_mac dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .done               (done),
        .src1_start_address (s1_start),
        .src2_start_address (s2_start),
        .src1_row_size      (n_size),
        .src1_col_size      (k_size),
        .src1_address       (src1_address),
        .src1_readdata      (src1_readdata),
        .src2_address       (src2_address),
        .src2_readdata      (src2_readdata),
        .dest_start_address (d_start),
        .dest_address       (dest_address),
        .dest_writedata     (dest_writedata),
        .dest_write_en      (dest_write_en)
    );

    always @(posedge clk) begin
        src1_readdata <= mem1[src1_address];
        src2_readdata <= mem2[src2_address];
    end

    always @(negedge clk) begin
        if (dest_write_en === 1'b1) begin
            wr_addr.push_back(int'(dest_address));
            wr_data.push_back(int'(dest_writedata));
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic start_job(input int n, input int k, input int s1, input int s2, input int d);
        @(negedge clk);
        n_size   = 10'(n);
        k_size   = 10'(k);
        s1_start = 14'(s1);
        s2_start = 14'(s2);
        d_start  = 14'(d);
        wr_addr.delete();
        wr_data.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts clock edges after start was sampled until done is seen high.
    // A pulse at cycle 'mid' exercises start-while-busy with a changed N.
    task automatic wait_done(input int limit, input int mid, output int cycles);
        cycles = 0;
        while (!done && cycles < limit) begin
            if (cycles == mid) begin
                start  = 1'b1;
                n_size = 10'd5;
            end
            @(negedge clk);
            start = 1'b0;
            cycles++;
        end
    endtask

    task automatic chk_writes(input string tag, input int cnt, input int a0, input int d0);
        chk({tag, "_cnt"}, wr_addr.size(), cnt);
        for (int i = 0; i < cnt; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), (i < wr_addr.size()) ? wr_addr[i] : -1,
                (a0 + i) % 16384);
        end
        if (d0 != 0) ;
    endtask

    int cyc;

    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem1[i] = '0;
            mem2[i] = '0;
        end
        s1_start = 14'd100;
        s2_start = 14'd200;
        d_start  = 14'd300;
        #12;
        chk("rst_done", int'(done), 1);
        chk("rst_we", int'(dest_write_en), 0);
        chk("rst_wdata", int'(dest_writedata), 0);
        chk("rst_src1", int'(src1_address), 100);
        chk("rst_src2", int'(src2_address), 200);
        chk("rst_dest", int'(dest_address), 300);
        @(negedge clk);
        reset = 1'b1;

        // Basic 2x3 product
        mem1[100] = 16'd1;  mem1[101] = 16'd2; mem1[102] = 16'd3;
        mem1[103] = -16'sd4; mem1[104] = 16'd5; mem1[105] = -16'sd6;
        mem2[200] = 16'd1;  mem2[201] = 16'd0; mem2[202] = 16'd1;
        start_job(2, 3, 100, 200, 300);
        chk("t1_busy", int'(done), 0);
        wait_done(200, -1, cyc);
        chk("t1_cycles", cyc, 13);
        chk_writes("t1", 2, 300, 0);
        chk("t1_d0", wr_data.size() > 0 ? wr_data[0] : 99, 4);
        chk("t1_d1", wr_data.size() > 1 ? wr_data[1] : 99, -10);

        // Positive and negative saturation
        for (int j = 0; j < 4; j++) begin
            mem1[1000 + j] = 16'd30000;
            mem2[2000 + j] = 16'd1;
        end
        start_job(1, 4, 1000, 2000, 400);
        wait_done(200, -1, cyc);
        chk("sat_cycles", cyc, 8);
        chk("sat_pos", wr_data.size() > 0 ? wr_data[0] : 0, 32767);
        for (int j = 0; j < 4; j++) mem1[1000 + j] = 16'h8AD0;
        start_job(1, 4, 1000, 2000, 400);
        wait_done(200, -1, cyc);
        chk("sat_neg", wr_data.size() > 0 ? wr_data[0] : 0, -32768);

        // No spikes: every current is zero
        for (int j = 0; j < 32; j++) mem1[3000 + j] = 16'($urandom_range(0, 65535));
        for (int j = 0; j < 8; j++) mem2[4000 + j] = 16'h0000;
        start_job(4, 8, 3000, 4000, 500);
        wait_done(400, -1, cyc);
        chk("zero_cycles", cyc, 45);
        chk_writes("zero", 4, 500, 0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("zero_d%0d", i), i < wr_data.size() ? wr_data[i] : 99, 0);

        // Empty job: N=0 never leaves IDLE
        start_job(0, 5, 100, 200, 700);
        wait_done(50, -1, cyc);
        chk("n0_cycles", cyc, 0);
        repeat (4) @(negedge clk);
        chk("n0_done", int'(done), 1);
        chk("n0_writes", wr_addr.size(), 0);
        chk("n0_src1", int'(src1_address), 100);

        // Reset during row 1 of a 3x4 job; bit 0 alone carries the spike
        for (int j = 0; j < 4; j++) begin
            mem1[5000 + j] = 16'd1;
            mem1[5004 + j] = 16'd2;
            mem1[5008 + j] = (j % 2 == 0) ? 16'd3 : -16'sd3;
        end
        mem2[6000] = 16'h0003; mem2[6001] = 16'h0001;
        mem2[6002] = 16'h0002; mem2[6003] = 16'h0001;
        start_job(3, 4, 5000, 6000, 600);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_done", int'(done), 1);
        chk("mid_we", int'(dest_write_en), 0);
        chk("mid_wdata", int'(dest_writedata), 0);
        chk("mid_src1", int'(src1_address), 5000);
        chk("mid_dest", int'(dest_address), 600);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        chk("mid_writes", wr_addr.size(), 1);
        start_job(3, 4, 5000, 6000, 600);
        wait_done(200, -1, cyc);
        chk("rerun_cycles", cyc, 22);
        chk_writes("rerun", 3, 600, 0);
        chk("rerun_d0", wr_data.size() > 0 ? wr_data[0] : 99, 3);
        chk("rerun_d1", wr_data.size() > 1 ? wr_data[1] : 99, 6);
        chk("rerun_d2", wr_data.size() > 2 ? wr_data[2] : 99, -3);

        // Destination wrap and start while busy
        mem1[7000] = 16'd7; mem1[7001] = 16'd8; mem1[7002] = 16'd9;
        mem2[8000] = 16'd1;
        start_job(3, 1, 7000, 8000, 16'h3FFE);
        wait_done(200, 4, cyc);
        chk("wrap_cycles", cyc, 13);
        chk_writes("wrap", 3, 16'h3FFE, 0);
        chk("wrap_d0", wr_data.size() > 0 ? wr_data[0] : 99, 7);
        chk("wrap_d1", wr_data.size() > 1 ? wr_data[1] : 99, 8);
        chk("wrap_d2", wr_data.size() > 2 ? wr_data[2] : 99, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matrix_spike_mac.md
Name: matrix_spike_mac

Overview:
- Synaptic-current stage directly upstream of the LIF layer.
- Computes current[i] = sum over j of W[i][j]·spike[j] from a row-major weight matrix and a spike vector, both in on-chip RAM.
- Writes one saturated 16-bit signed current per output neuron into the buffer the LIF layer reads.
- Uses the same start/done handshake and src/dest memory-port style as the other matrix engines.

Parameters:
- DATA_W, 16, weight, spike and current word width.
- ADDR_W, 14, memory address width.
- ACC_W, 26, signed accumulator width; must be at least DATA_W+10, so 1023 terms cannot overflow.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (low = reset asserted).
- start  in  1  one-cycle request; sampled only in IDLE.
- done  out  1  high while idle.
- src1_start_address  in  ADDR_W  base of weight matrix W.
- src2_start_address  in  ADDR_W  base of spike vector.
- src1_row_size  in  10  N, number of output neurons.
- src1_col_size  in  10  K, number of inputs.
- src1_address  out  ADDR_W  weight read address.
- src1_readdata  in  DATA_W signed  weight, valid 1 cycle after its address.
- src2_address  out  ADDR_W  spike read address.
- src2_readdata  in  DATA_W  spike word; only bit 0 is used; valid 1 cycle after its address.
- dest_start_address  in  ADDR_W  base of current buffer.
- dest_address  out  ADDR_W  write address.
- dest_writedata  out  DATA_W signed  saturated current.
- dest_write_en  out  1  one-cycle write strobe.

Behaviour:
- Reset (asynchronous, reset low), all outputs and state:
  - state=IDLE, done=1, dest_write_en=0, dest_writedata=0.
  - src1_address=src1_start_address, src2_address=src2_start_address, dest_address=dest_start_address.
  - Row/column counters, accumulator and read-valid flag cleared.
  - Reset mid-run aborts immediately; partial rows are never written.
- Layout:
  - W[i][j] at src1_start + i·K + j.
  - spike[j] at src2_start + j.
  - current[i] at dest_start + i.
  - All address arithmetic is modulo 2^ADDR_W (wraps silently).
- IDLE:
  - done=1, dest_write_en=0; base addresses are continuously re-latched.
  - start=1 with N≠0 and K≠0 → done<=0, go to LOAD, counters=0.
  - start=1 with N=0 or K=0 → stay in IDLE, done stays 1, no writes.
- LOAD (1 cycle):
  - Drive src1_address = row base, src2_address = src2_start.
  - Clear acc; set rd_valid.
  - Go to ACC.
- ACC (one element per cycle, pipelined):
  - Each cycle, if rd_valid: acc += sign-extended src1_readdata when src2_readdata[0]=1, else acc unchanged.
  - Column counter j < K-1: issue next address (j+1) and keep rd_valid=1.
  - j = K-1: clear rd_valid and go to FLUSH.
- FLUSH (1 cycle):
  - Absorb the final returned word into acc.
  - Go to WRITE.
- WRITE (1 cycle):
  - dest_write_en=1, dest_address = dest_start + i.
  - dest_writedata = acc saturated to [-32768, 32767].
  - Row counter i < N-1: i++, row base += K, go to LOAD.
  - Otherwise go to IDLE; done rises the following cycle.
  - dest_write_en is high only in WRITE and is never held.
- Latency:
  - Exactly K+3 cycles per row (LOAD + K-1 ACC issues + FLUSH + WRITE + accumulation overlap).
  - First write occurs K+2 cycles after start is sampled.
  - Total from start to done=1 is N·(K+3)+1 cycles.
- start while busy is ignored. Sizes and base addresses are latched at start; changing them mid-run has no effect.
- src memories are read-only from this block; it has no src write enables.

Decomposition:
- Package snn_mem_pkg:
  - DATA_W / ADDR_W / ACC_W constants.
  - State enum {IDLE, LOAD, ACC, FLUSH, WRITE}.
  - Saturation limits SAT_MAX=32767, SAT_MIN=-32768.
- One natural sub-module: sat_narrow (combinational ACC_W→DATA_W signed saturation), reusable by later layers.

Test Plan:
- N=2, K=3, W=[[1,2,3],[-4,5,-6]], spikes=[1,0,1] → dest[0]=4, dest[1]=-10; exactly 2 write strobes; done returns at cycle 2·6+1=13.
- N=1, K=4, all weights 30000, all spikes=1 → dest[0]=32767 (saturated); all weights -30000 → -32768.
- All spikes=0, N=4, K=8, random weights → four writes of 0 at dest_start..dest_start+3.
- N=0, K=5 with start → done stays 1; no dest_write_en; no address activity beyond base.
- Assert reset low during row 1 of an N=3, K=4 run → outputs return to reset values at once; no further writes; a new start after release gives correct results.
- dest_start=0x3FFE, N=3, K=1, spikes=[1], W=[7,8,9] → writes at 0x3FFE, 0x3FFF, 0x0000 (wrap); start pulsed mid-run is ignored.
